alu_sched: RTL
==============

ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 The block SHALL have parameter W, default 4, operand width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters (fixed power of two, 2..8).
REQ-003 clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  NREQ  per-requester request, level held until granted.
REQ-006 code_i  input  2*NREQ  per-requester opcode; requester k uses bits [2k+1:2k].
REQ-007 a_i  input  W*NREQ  per-requester operand a; requester k uses slice k.
REQ-008 b_i  input  W*NREQ  per-requester operand b; requester k uses slice k.
REQ-009 gnt  output  NREQ  one-hot accept pulse, one cycle, to the requester whose operands were captured.
REQ-010 out_valid  output  1  result register holds an unconsumed result.
REQ-011 out_ready  input  1  consumer accepts the result when high with out_valid.
REQ-012 out_id  output  log2(NREQ)  index of requester that owns the result.
REQ-013 out_c  output  W+1  ALU result.
REQ-014 op_cnt  output  8  count of results consumed, wraps 255 -> 0.

Function
REQ-015 Opcodes SHALL be: 0 add, a+b with carry in bit W; 1 subtract, (a-b) mod 2^(W+1); 2 bitwise and, zero-extended; 3 bitwise or, zero-extended.
REQ-016 One shared ALU instance SHALL serve all requesters; only the granted requester's operands reach it.
REQ-017 The block SHALL accept a request in a cycle when any req is high and (out_valid is low or out_ready is high).
REQ-018 On accept, out_c, out_id and out_valid=1 SHALL update at the next rising edge (latency 1 cycle from accept to out_valid).
REQ-019 gnt SHALL be asserted combinationally in the accept cycle, one-hot, and zero in all other cycles.
REQ-020 Arbitration SHALL be round-robin: search starts at the index after the last granted requester, wrapping NREQ-1 -> 0; after reset the search starts at 0.
REQ-021 The round-robin pointer SHALL advance only on accept, never on stalled cycles.
REQ-022 A held result SHALL keep out_c/out_id stable while out_valid=1 and out_ready=0.
REQ-023 When out_valid=1, out_ready=1 and no req is high, out_valid SHALL clear at the next edge.
REQ-024 Simultaneous consume and accept SHALL replace the result with no bubble cycle (full throughput, one op per cycle).
REQ-025 op_cnt SHALL increment by one on each cycle where out_valid and out_ready are both high, wrapping at 255.
REQ-026 Control state SHALL be two states: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on accept; FULL->EMPTY on consume without accept; FULL->FULL on stall or consume-with-accept.
REQ-027 A requester deasserting req before grant SHALL be treated as withdrawn with no side effects.

Reset
REQ-028 While rst_n is low at a rising edge: out_valid=0, out_c=0, out_id=0, op_cnt=0, round-robin pointer=NREQ-1 (so search starts at 0), state EMPTY.
REQ-029 gnt SHALL be 0 in any cycle where rst_n is low, regardless of req.
REQ-030 Reset mid-operation SHALL discard a held result without counting it.

Structure
REQ-031 Opcode constants (ADD, SUB, AND, OR) and the state encoding SHALL live in a shared package alu_pkg.
REQ-032 The ALU datapath SHALL be one sub-module alu_core (code, a, b -> W+1-bit c), combinational, instantiated once.
REQ-033 Arbiter and result register SHALL stay inside alu_sched.

Verification
REQ-034 Reset then req=0001, code0=0, a0=0111, b0=1101 -> gnt=0001 in that cycle, next cycle out_valid=1, out_id=0, out_c=10100.
REQ-035 req=1111 held, out_ready=1 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... and op_cnt=8 after last consume.
REQ-036 out_valid=1 with out_ready=0 for 3 cycles, req=0100 -> gnt stays 0000, out_c/out_id stable; out_ready=1 -> gnt=0100 same cycle, new result next cycle.
REQ-037 Opcodes on requester 1: code=1 a=0001 b=0011 -> out_c=11110; code=2 a=1001 b=0011 -> 00001; code=3 a=0011 b=0001 -> 00011.
REQ-038 256 consumed results -> op_cnt wraps to 0; rst_n low while out_valid=1 -> out_valid=0, op_cnt=0, next accepted grant goes to lowest pending index.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcode and control-state encodings.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage : alu_pkg

// File: rtl/alu_core.sv
// Combinational ALU shared by all requesters; result is one bit wider than the operands.
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  alu_op_e        code_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [W:0]     c_o
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    c_o = '0;
    case (code_i)
      OP_ADD:  c_o = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  c_o = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  c_o = {1'b0, a_i & b_i};
      OP_OR:   c_o = {1'b0, a_i | b_i};
      default: c_o = '0;
    endcase
  end

endmodule : alu_core

// File: rtl/alu_sched.sv
// Round-robin arbiter feeding one shared ALU into a single-entry result register
// with valid/ready handshake and a consumed-result counter.
module alu_sched
  import alu_pkg::*;
#(
  parameter int W    = 4,
  parameter int NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     code_i,
  input  logic [W*NREQ-1:0]     a_i,
  input  logic [W*NREQ-1:0]     b_i,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(NREQ)-1:0] out_id,
  output logic [W:0]            out_c,
  output logic [7:0]            op_cnt
);

  localparam int IW = $clog2(NREQ);

  state_e        state_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] out_id_q;
  logic [W:0]    out_c_q;
  logic [7:0]    op_cnt_q;

  logic [IW-1:0] sel;
  logic          accept;
  logic          consume;
  logic [1:0]    sel_code;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic [W:0]    alu_c;

  // Search starts one past the last grant; the IW-bit sum wraps NREQ-1 -> 0.
  always_comb begin
    sel = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[IW'(ptr_q + IW'(i))]) sel = IW'(ptr_q + IW'(i));
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign consume   = out_valid & out_ready;
  assign accept    = rst_n & (|req) & (~out_valid | out_ready);
  assign gnt       = accept ? (NREQ'(1) << sel) : '0;

  always_comb begin
    sel_code = code_i[2*sel +: 2];
    sel_a    = a_i[W*sel +: W];
    sel_b    = b_i[W*sel +: W];
  end

  alu_core #(.W(W)) u_alu_core (
    .code_i (alu_op_e'(sel_code)),
    .a_i    (sel_a),
    .b_i    (sel_b),
    .c_o    (alu_c)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= IW'(NREQ - 1);
      out_id_q <= '0;
      out_c_q  <= '0;
      op_cnt_q <= '0;
    end else begin
      if (consume) op_cnt_q <= op_cnt_q + 8'd1;
      if (accept) begin
        out_c_q  <= alu_c;
        out_id_q <= sel;
        ptr_q    <= sel;
      end
      case (state_q)
        ST_EMPTY: if (accept) state_q <= ST_FULL;
        ST_FULL:  if (out_ready && !accept) state_q <= ST_EMPTY;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  assign out_id = out_id_q;
  assign out_c  = out_c_q;
  assign op_cnt = op_cnt_q;

endmodule : alu_sched
